rom_bus_bridge: RTL and testbench
=================================

ROM_BUS_BRIDGE -- requirements
Module: rom_bus_bridge

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, byte base of the 1 KiB memory window; SHALL be 1 KiB aligned.
REQ-002 Parameter: WRITE_ENABLE, 1, 0 = window is read-only and writes are acknowledged but discarded.
REQ-003 Single clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 mem_valid  in  1  picoRV32 native-bus request.
REQ-007 mem_addr  in  32  byte address, held stable while mem_valid=1.
REQ-008 mem_wdata  in  32  write data.
REQ-009 mem_wstrb  in  4  byte strobes; 4'h0 = read.
REQ-010 mem_ready  out  1  one-cycle completion pulse.
REQ-011 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-012 ram_addr  out  8  word address to the 256x32 sync-read RAM, equal to mem_addr[9:2] (combinational).
REQ-013 ram_wen  out  1  registered RAM write enable.
REQ-014 ram_wdata  out  32  registered RAM write data.
REQ-015 ram_rdata  in  32  RAM read data, valid one cycle after ram_addr is sampled.

Function
REQ-016 Hit SHALL be mem_valid=1 and mem_addr[31:10]=BASE_ADDR[31:10]; mem_addr[1:0] SHALL be ignored.
REQ-017 States: IDLE, RD, WR, RMW_RD, RMW_WR, ACK; requests SHALL be accepted only in IDLE.
REQ-018 Read (wstrb=0): IDLE->RD->ACK; in RD, mem_rdata SHALL be loaded from ram_rdata; mem_ready=1 in ACK, two cycles after the accept cycle.
REQ-019 Full write (wstrb=4'hF): IDLE->WR->ACK; ram_wen=1 with ram_wdata=mem_wdata during WR only.
REQ-020 Partial write (other nonzero wstrb): IDLE->RMW_RD->RMW_WR->ACK; merged byte i = wstrb[i] ? mem_wdata byte i : ram_rdata byte i, registered at the end of RMW_RD; ram_wen=1 during RMW_WR only.
REQ-021 ACK SHALL last exactly one cycle, then IDLE; a new hit in the following IDLE cycle SHALL be accepted.
REQ-022 Non-hit requests SHALL leave the state in IDLE, with mem_ready=0 and ram_wen=0.
REQ-023 WRITE_ENABLE=0: writes SHALL follow the same state path and timing, with ram_wen held 0.
REQ-024 mem_rdata SHALL hold its last value outside ACK; on writes it SHALL be unchanged.
REQ-025 Once accepted, a transaction SHALL complete even if mem_valid drops (protocol violation); no abort path.
REQ-026 ram_wen SHALL never be high for more than one consecutive cycle per transaction.

Reset
REQ-027 With rst=1 sampled at a rising edge, the next cycle SHALL have state=IDLE, mem_ready=0, mem_rdata=0, ram_wen=0, ram_wdata=0.
REQ-028 Reset mid-transaction SHALL drop the transaction without mem_ready; a ram_wen already high in the reset cycle still completes in the RAM.
REQ-029 rst=1 SHALL override mem_valid in the same cycle.

Structure
REQ-030 Package rom_bus_bridge_pkg SHALL hold the state encoding constants and WORD_ADDR_W=8.
REQ-031 One sub-module, wstrb_merge (combinational 4-byte lane merge), SHALL be instantiated for REQ-020.
REQ-032 Target size is 120-400 RTL lines; no other sub-modules.

Verification
REQ-033 RAM word 5=32'hAABBCCDD; read addr 0x14 -> mem_ready in cycle 2 after accept, mem_rdata=32'hAABBCCDD.
REQ-034 Write addr 0x20 data 32'h12345678 wstrb=F -> one ram_wen pulse at ram_addr 8 with 32'h12345678; readback matches.
REQ-035 Word 3=32'h11223344; write addr 0x0C data 32'hFFEEDDCC wstrb=4'b0101 -> word 3=32'h11EE33CC, mem_ready in cycle 3 after accept.
REQ-036 BASE_ADDR=32'h0001_0000; access to 0x0000_0014 -> no mem_ready and no ram_wen for 10 cycles.
REQ-037 WRITE_ENABLE=0; full write to 0x04 -> mem_ready pulse, ram_wen stays 0, word 1 unchanged.
REQ-038 rst asserted in RMW_RD -> no ram_wen and no mem_ready afterwards; the next read is served normally.

Source files
------------

// File: rtl/rom_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_bus_bridge_pkg
//  Description : Shared constants and state encoding for the picoRV32
//                native-bus to 256x32 sync-read RAM bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_bus_bridge_pkg;

    // Word address width of the backing RAM (256 words = 1 KiB window)
    localparam int WORD_ADDR_W = 8;

    // Byte-strobe patterns that select the read and full-write paths
    localparam logic [3:0] c_WSTRB_READ = 4'h0;
    localparam logic [3:0] c_WSTRB_FULL = 4'hF;

    // Bridge FSM states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_ACK    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_bus_bridge_wstrb_merge.sv
`default_nettype none
// ============================================================================
//  Module      : wstrb_merge
//  Description : Combinational 4-lane byte merge. Each output byte takes the
//                new write byte when its strobe is set, else the old RAM byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module wstrb_merge (
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_new_data,
    input  logic [31:0] i_old_data,
    output logic [31:0] o_merged
);

    // One independent mux per byte lane
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign o_merged[8*i +: 8] = i_wstrb[i] ? i_new_data[8*i +: 8]
                                                   : i_old_data[8*i +: 8];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rom_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : rom_bus_bridge
//  Description : Bridges the picoRV32 native memory bus onto a 256x32
//                synchronous-read RAM mapped at a 1 KiB aligned window.
//                Reads take RD->ACK, full writes WR->ACK, partial writes
//                do a read-modify-write RMW_RD->RMW_WR->ACK.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_bus_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter bit          WRITE_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  ram_addr,
    output logic        ram_wen,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    import rom_bus_bridge_pkg::*;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_hit;
    logic        w_accept;
    logic [31:0] w_merged;
    logic [31:0] r_mem_rdata;
    logic        r_ram_wen;
    logic [31:0] r_ram_wdata;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        w_unused;

    // Byte offset bits never matter for word accesses
    assign w_unused = ^mem_addr[1:0];

    assign w_hit    = mem_valid && (mem_addr[31:10] == BASE_ADDR[31:10]);
    assign w_accept = (r_state == ST_IDLE) && w_hit;

    // RAM word address follows the bus address directly so the RAM can
    // sample it in the accept cycle and present data one cycle later
    assign ram_addr  = mem_addr[WORD_ADDR_W+1:2];
    assign ram_wen   = r_ram_wen;
    assign ram_wdata = r_ram_wdata;
    assign mem_rdata = r_mem_rdata;
    assign mem_ready = (r_state == ST_ACK);

    // Lane merge of the latched write data over the current RAM word
    wstrb_merge u_merge (
        .i_wstrb    (r_wstrb),
        .i_new_data (r_wdata),
        .i_old_data (ram_rdata),
        .o_merged   (w_merged)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; once accepted a transaction always runs to ACK
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    if (mem_wstrb == c_WSTRB_READ) begin
                        w_next_state = ST_RD;
                    end else if (mem_wstrb == c_WSTRB_FULL) begin
                        w_next_state = ST_WR;
                    end else begin
                        w_next_state = ST_RMW_RD;
                    end
                end
            end
            ST_RD:     w_next_state = ST_ACK;
            ST_WR:     w_next_state = ST_ACK;
            ST_RMW_RD: w_next_state = ST_RMW_WR;
            ST_RMW_WR: w_next_state = ST_ACK;
            ST_ACK:    w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Latch write data and strobes at accept so a dropped request still
    // completes with the values it was accepted with
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdata <= 32'h0;
            r_wstrb <= 4'h0;
        end else if (w_accept) begin
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
        end
    end

    // Datapath: read capture and single-cycle RAM write pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_rdata <= 32'h0;
            r_ram_wen   <= 1'b0;
            r_ram_wdata <= 32'h0;
        end else begin
            r_ram_wen <= 1'b0;
            if (w_accept && (mem_wstrb == c_WSTRB_FULL)) begin
                r_ram_wen   <= WRITE_ENABLE;
                r_ram_wdata <= mem_wdata;
            end
            if (r_state == ST_RMW_RD) begin
                r_ram_wen   <= WRITE_ENABLE;
                r_ram_wdata <= w_merged;
            end
            if (r_state == ST_RD) begin
                r_mem_rdata <= ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_bus_bridge
//  Description : Scoreboard bench for rom_bus_bridge. Three instances share
//                one bus: default (u0), BASE_ADDR=0x10000 (u1, never hit
//                by window-0 traffic) and WRITE_ENABLE=0 (u2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_bus_bridge;

    typedef struct {
        int          acc;
        int          lat;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } wexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr  = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;

    logic        mem_ready0, mem_ready1, mem_ready2;
    logic [31:0] mem_rdata0, mem_rdata1, mem_rdata2;
    logic [7:0]  ram_addr0, ram_addr1, ram_addr2;
    logic        ram_wen0, ram_wen1, ram_wen2;
    logic [31:0] ram_wdata0, ram_wdata1, ram_wdata2;
    logic [31:0] ram_rdata0, ram_rdata1, ram_rdata2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    exp_t  q0[$];
    exp_t  q2[$];
    wexp_t wq[$];

    logic [31:0] ref0 [256];
    logic [31:0] ref2 [256];
    logic [31:0] last_rd0 = 32'h0;
    logic [31:0] last_rd2 = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rom_bus_bridge u0 (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready0),
        .mem_rdata(mem_rdata0), .ram_addr(ram_addr0), .ram_wen(ram_wen0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
    );

    rom_bus_bridge #(.BASE_ADDR(32'h0001_0000), .WRITE_ENABLE(1'b1)) u1 (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready1),
        .mem_rdata(mem_rdata1), .ram_addr(ram_addr1), .ram_wen(ram_wen1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    rom_bus_bridge #(.BASE_ADDR(32'h0000_0000), .WRITE_ENABLE(1'b0)) u2 (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready2),
        .mem_rdata(mem_rdata2), .ram_addr(ram_addr2), .ram_wen(ram_wen2),
        .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 5) return 32'hAABB_CCDD;
        if (i == 3) return 32'h1122_3344;
        return {b ^ 8'h5A, ~b, b, b ^ 8'hC3};
    endfunction

    // Behavioural RAMs: sync read, write on wen, one per instance
    logic [31:0] ram0 [256];
    logic [31:0] ram1 [256];
    logic [31:0] ram2 [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram0[i] = init_word(i);
            ram1[i] = init_word(i);
            ram2[i] = init_word(i);
        end
        forever begin
            @(posedge clk);
            if (ram_wen0) ram0[ram_addr0] <= ram_wdata0;
            if (ram_wen1) ram1[ram_addr1] <= ram_wdata1;
            if (ram_wen2) ram2[ram_addr2] <= ram_wdata2;
            ram_rdata0 <= ram0[ram_addr0];
            ram_rdata1 <= ram1[ram_addr1];
            ram_rdata2 <= ram2[ram_addr2];
        end
    end

    // Monitor: pops expectations whenever a DUT presents a response
    always @(negedge clk) begin
        exp_t  e;
        wexp_t w;
        if (mon_en) begin
            if (mem_ready0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL ready0_unexpected cyc=%0d rdata=%h", cyc, mem_rdata0);
                end else begin
                    e = q0.pop_front();
                    if (cyc != e.acc + e.lat || mem_rdata0 !== e.rdata) begin
                        errors++;
                        $display("FAIL ready0 cyc=%0d rdata=%h, required cyc=%0d rdata=%h",
                                 cyc, mem_rdata0, e.acc + e.lat, e.rdata);
                    end
                end
            end
            if (mem_ready2) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL ready2_unexpected cyc=%0d rdata=%h", cyc, mem_rdata2);
                end else begin
                    e = q2.pop_front();
                    if (cyc != e.acc + e.lat || mem_rdata2 !== e.rdata) begin
                        errors++;
                        $display("FAIL ready2 cyc=%0d rdata=%h, required cyc=%0d rdata=%h",
                                 cyc, mem_rdata2, e.acc + e.lat, e.rdata);
                    end
                end
            end
            if (ram_wen0) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL wen0_unexpected cyc=%0d addr=%0d data=%h", cyc, ram_addr0, ram_wdata0);
                end else begin
                    w = wq.pop_front();
                    if (cyc != w.cyc || ram_addr0 !== w.addr || ram_wdata0 !== w.data) begin
                        errors++;
                        $display("FAIL wen0 cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                                 cyc, ram_addr0, ram_wdata0, w.cyc, w.addr, w.data);
                    end
                end
            end
            checks++;
            if (ram_wen2 !== 1'b0) begin
                errors++;
                $display("FAIL wen2_readonly cyc=%0d wen=%b, required 0", cyc, ram_wen2);
            end
            checks++;
            if (mem_ready1 !== 1'b0 || ram_wen1 !== 1'b0) begin
                errors++;
                $display("FAIL miss_u1 cyc=%0d ready=%b wen=%b, required 0 0", cyc, mem_ready1, ram_wen1);
            end
        end
    end

    // Reference model: records what each hit request must produce
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int acc);
        int          wd;
        int          lat;
        logic [31:0] m;
        exp_t        e0, e2;
        wexp_t       w;
        wd = int'(a[9:2]);
        if (s == 4'h0) begin
            lat = 2;
            last_rd0 = ref0[wd];
            last_rd2 = ref2[wd];
        end else begin
            lat = (s == 4'hF) ? 2 : 3;
            for (int i = 0; i < 4; i++)
                m[8*i +: 8] = s[i] ? d[8*i +: 8] : ref0[wd][8*i +: 8];
            ref0[wd] = m;
            w.cyc  = acc + lat - 1;
            w.addr = 8'(wd);
            w.data = m;
            wq.push_back(w);
        end
        e0.acc = acc; e0.lat = lat; e0.rdata = last_rd0;
        e2.acc = acc; e2.lat = lat; e2.rdata = last_rd2;
        q0.push_back(e0);
        q2.push_back(e2);
    endtask

    // Driver: called just after a falling edge with the DUT in IDLE
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hit);
        bit done;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        if (hit) begin
            model(a, d, s, cyc);
            done = 1'b0;
            for (int k = 0; k < 8 && !done; k++) begin
                @(negedge clk);
                if (mem_ready0) done = 1'b1;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL timeout addr=%h wstrb=%h ready=0, required 1", a, s);
            end
        end else begin
            repeat (10) @(negedge clk);
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        int          kind;
        for (int i = 0; i < 256; i++) begin
            ref0[i] = init_word(i);
            ref2[i] = init_word(i);
        end

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_ready",  {31'h0, mem_ready0}, 32'h0);
        check_val("rst_rdata",  mem_rdata0, 32'h0);
        check_val("rst_wen",    {31'h0, ram_wen0}, 32'h0);
        check_val("rst_wdata",  ram_wdata0, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed: read word 5
        issue(32'h0000_0014, 32'h0, 4'h0, 1'b1);
        check_val("read_w5", mem_rdata0, 32'hAABB_CCDD);
        // Full write then readback
        issue(32'h0000_0020, 32'h1234_5678, 4'hF, 1'b1);
        issue(32'h0000_0020, 32'h0, 4'h0, 1'b1);
        check_val("readback_w8", mem_rdata0, 32'h1234_5678);
        // Partial write with ignored byte offset bits, then readback
        issue(32'h0000_000E, 32'hFFEE_DDCC, 4'b0101, 1'b1);
        issue(32'h0000_000C, 32'h0, 4'h0, 1'b1);
        check_val("readback_w3", mem_rdata0, 32'h11EE_33CC);
        // Full write to word 1: read-only instance must keep its word
        issue(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1);
        issue(32'h0000_0004, 32'h0, 4'h0, 1'b1);
        check_val("ro_w1", mem_rdata2, init_word(1));
        // Miss for u0/u2 window, u1 also misses
        issue(32'h0000_0414, 32'h0, 4'h0, 1'b0);

        // Reset during RMW_RD drops the transaction
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_001C;
        mem_wdata = 32'h5555_AAAA;
        mem_wstrb = 4'b0011;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        check_val("midrst_rdata", mem_rdata0, 32'h0);
        last_rd0 = 32'h0;
        last_rd2 = 32'h0;
        repeat (5) @(negedge clk);
        issue(32'h0000_001C, 32'h0, 4'h0, 1'b1);
        check_val("midrst_w7", mem_rdata0, init_word(7));

        // Randomized traffic, including back-to-back and misses
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            d = $urandom;
            case ($urandom_range(0, 2))
                0:       s = 4'h0;
                1:       s = 4'hF;
                default: s = 4'($urandom_range(1, 14));
            endcase
            if (kind == 0) begin
                a = 32'h0000_0400 | ($urandom & 32'h0000_03FF);
                issue(a, d, s, 1'b0);
            end else begin
                a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
                issue(a, d, s, 1'b1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check_val("q0_empty", 32'(q0.size()), 32'h0);
        check_val("q2_empty", 32'(q2.size()), 32'h0);
        check_val("wq_empty", 32'(wq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
